rc_transfer_bridge: RTL and testbench
=====================================

// Module: rc_transfer_bridge
// PURPOSE
//  Downstream stage of the UART transfer handler engine. Takes its single-cycle
//  write/read transfer pulses (address + write data), issues one request on the
//  ring-controller (RC) request channel, waits for the matching RC response and
//  returns a one-cycle write/read response pulse plus read data to the engine.
//  A per-transfer timeout guards against a silent RC.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  cycles from request issue to forced abort; legal range 2..65535
//  CNT_W           16    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk                 in   1   clock
//  rst                 in   1   synchronous reset, active-high
//  write_transfer_valid in  1   1-cycle pulse from engine: issue write
//  read_transfer_valid in   1   1-cycle pulse from engine: issue read
//  address             in   32  transfer address, sampled with the pulse
//  data_out            in   32  write data from engine, sampled with write pulse
//  data_in             out  32  read data to engine
//  write_resp_valid    out  1   1-cycle pulse: write completed
//  read_resp_valid     out  1   1-cycle pulse: read completed, data_in valid
//  rc_timeout          out  1   1-cycle pulse: transfer aborted by timeout
//  transfer_err        out  1   1-cycle pulse: request rejected (see BEHAVIOUR)
//  busy                out  1   high from accept until completion/abort
//  rc_req_valid        out  1   RC request valid
//  rc_req_ready        in   1   RC request ready
//  rc_req_opcode       out  1   0=read, 1=write
//  rc_req_address      out  32  RC request address
//  rc_req_data         out  32  RC request write data (0 for reads)
//  rc_rsp_valid        in   1   RC response valid, single cycle
//  rc_rsp_opcode       in   1   0=read response, 1=write response
//  rc_rsp_data         in   32  RC read response data
// BEHAVIOUR
//  - Reset: state IDLE; all pulses, rc_req_valid, busy = 0; data_in, rc_req_* = 0;
//    timeout counter = 0. Reset mid-operation aborts silently (no pulse emitted).
//  - FSM IDLE -> REQ -> WAIT_RSP -> DONE -> IDLE; abort path REQ/WAIT_RSP -> IDLE.
//  - IDLE: exactly one of write/read_transfer_valid high -> latch address, data,
//    opcode into rc_req_* regs; next state REQ; busy=1 from next cycle.
//    Both high in same cycle -> nothing issued, transfer_err pulses next cycle.
//  - Pulses arriving while busy are dropped and flag transfer_err (1 cycle later).
//  - REQ: rc_req_valid=1, request fields stable until rc_req_valid&rc_req_ready;
//    on handshake -> WAIT_RSP. Earliest handshake is cycle after accept.
//  - WAIT_RSP: rc_rsp_valid with rc_rsp_opcode == latched opcode -> DONE, data_in
//    loads rc_rsp_data on a read. Mismatched opcode responses are ignored.
//    rc_rsp_valid while in REQ or IDLE is ignored.
//  - DONE (1 cycle): write_resp_valid or read_resp_valid=1, busy=0 next cycle.
//    Min accept-to-response-pulse latency: 3 cycles (ready and rsp immediate).
//  - Timeout counter clears on accept, increments every REQ/WAIT_RSP cycle; on
//    reaching TIMEOUT_CYCLES: rc_timeout pulses, rc_req_valid drops, -> IDLE.
//    Matching response in the terminal-count cycle wins: completion, no timeout.
//    Counter saturates; never wraps.
//  - data_in holds last read result; unchanged by writes, timeouts, errors.
//  - New transfer accepted in IDLE the cycle after DONE/abort (back-to-back ok).
// CONFIGURATION
//  RC_BRIDGE_ALIGN_CHECK_EN defined: pulse with address[1:0]!=0 is rejected in
//    IDLE: no RC request, transfer_err pulses next cycle, state stays IDLE.
//  Not defined: addresses forwarded unmodified, no alignment check.
// TESTING
//  - write addr=0x0000_1000 data=0xDEAD_BEEF, ready=1, rsp(op=1) 1 cycle after
//    handshake -> rc_req_* match, write_resp_valid 1 pulse, busy low after.
//  - read addr=0x0000_2004, ready delayed 5 cycles, rsp data=0x1234_5678 ->
//    request held stable 5 cycles, read_resp_valid pulse, data_in=0x1234_5678.
//  - TIMEOUT_CYCLES=8, read, ready=1, no rsp -> rc_timeout exactly 8 cycles after
//    accept; rsp in that cycle instead -> read_resp_valid, no rc_timeout.
//  - both pulses same cycle; write pulse while busy -> transfer_err, no extra req.
//  - rst asserted in WAIT_RSP -> next cycle IDLE, all outputs 0, no pulses.
//  - ALIGN_CHECK_EN on, write addr=0x0000_1002 -> transfer_err, rc_req_valid 0;
//    off -> request issued with address 0x0000_1002.

Source files
------------

// File: rtl/rc_transfer_bridge_if.sv
// Ring-controller request/response channel between the transfer bridge and the RC.
interface rc_transfer_bridge_if;
  logic        rc_req_valid;
  logic        rc_req_ready;
  logic        rc_req_opcode;
  logic [31:0] rc_req_address;
  logic [31:0] rc_req_data;
  logic        rc_rsp_valid;
  logic        rc_rsp_opcode;
  logic [31:0] rc_rsp_data;

  modport master (
    output rc_req_valid, rc_req_opcode, rc_req_address, rc_req_data,
    input  rc_req_ready, rc_rsp_valid, rc_rsp_opcode, rc_rsp_data
  );

  modport slave (
    input  rc_req_valid, rc_req_opcode, rc_req_address, rc_req_data,
    output rc_req_ready, rc_rsp_valid, rc_rsp_opcode, rc_rsp_data
  );
endinterface

// File: rtl/rc_transfer_bridge.sv
// Bridges engine write/read pulses to one RC request/response with per-transfer timeout.
// Optional: define RC_BRIDGE_ALIGN_CHECK_EN to reject non word-aligned addresses.
module rc_transfer_bridge #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_transfer_valid,
  input  logic                 read_transfer_valid,
  input  logic [31:0]          address,
  input  logic [31:0]          data_out,
  output logic [31:0]          data_in,
  output logic                 write_resp_valid,
  output logic                 read_resp_valid,
  output logic                 rc_timeout,
  output logic                 transfer_err,
  output logic                 busy,
  rc_transfer_bridge_if.master rc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             one_pulse, any_pulse, misaligned;
  logic             accept, reject, rsp_match, term, tmo;

  assign one_pulse = write_transfer_valid ^ read_transfer_valid;
  assign any_pulse = write_transfer_valid | read_transfer_valid;
  assign rsp_match = rc.rc_rsp_valid && (rc.rc_rsp_opcode == rc.rc_req_opcode);
  assign term      = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef RC_BRIDGE_ALIGN_CHECK_EN
  assign misaligned = |address[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (one_pulse && !misaligned) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end else if (any_pulse) begin
          reject = 1'b1;
        end
      end
      REQ: begin
        reject = any_pulse;
        // Timeout has priority over a late handshake; only a matching response can beat it.
        if (term) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end else if (rc.rc_req_ready) begin
          state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        reject = any_pulse;
        if (rsp_match) begin
          state_nxt = DONE;
        end else if (term) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        reject    = any_pulse;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt               <= '0;
      data_in           <= '0;
      rc_timeout        <= 1'b0;
      transfer_err      <= 1'b0;
      rc.rc_req_opcode  <= 1'b0;
      rc.rc_req_address <= '0;
      rc.rc_req_data    <= '0;
    end else begin
      rc_timeout   <= tmo;
      transfer_err <= reject;
      if (accept) begin
        cnt               <= '0;
        rc.rc_req_opcode  <= write_transfer_valid;
        rc.rc_req_address <= address;
        rc.rc_req_data    <= write_transfer_valid ? data_out : 32'h0;
      end else if ((state == REQ || state == WAIT_RSP) && cnt != CNT_W'(TIMEOUT_CYCLES)) begin
        cnt <= cnt + 1'b1;
      end
      if (state == WAIT_RSP && rsp_match && !rc.rc_req_opcode)
        data_in <= rc.rc_rsp_data;
    end
  end

  assign rc.rc_req_valid  = (state == REQ);
  assign busy             = (state != IDLE);
  assign write_resp_valid = (state == DONE) &&  rc.rc_req_opcode;
  assign read_resp_valid  = (state == DONE) && !rc.rc_req_opcode;

endmodule

// File: tb/tb_rc_transfer_bridge.sv
// Scoreboard bench for rc_transfer_bridge: directed stimulus queues expected events, a monitor checks them.
module tb_rc_transfer_bridge;
  localparam int EV_WR = 0, EV_RD = 1, EV_TMO = 2, EV_ERR = 3;

  typedef struct { int kind; logic [31:0] data; int cyc; } ev_t;
  typedef struct { logic op; logic [31:0] addr; logic [31:0] data; } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_transfer_valid, read_transfer_valid;
  logic [31:0] address, data_out, data_in;
  logic        write_resp_valid, read_resp_valid, rc_timeout, transfer_err, busy;
  int          cyc = 0;
  int          checks = 0, failures = 0;
  int          a;
  ev_t         exp_q[$];
  req_t        req_q[$];

  rc_transfer_bridge_if ifc();

  rc_transfer_bridge #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .write_transfer_valid(write_transfer_valid), .read_transfer_valid(read_transfer_valid),
    .address(address), .data_out(data_out), .data_in(data_in),
    .write_resp_valid(write_resp_valid), .read_resp_valid(read_resp_valid),
    .rc_timeout(rc_timeout), .transfer_err(transfer_err), .busy(busy),
    .rc(ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [31:0] d, input int c);
    ev_t e;
    e.kind = kind; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_req(input logic op, input logic [31:0] ad, input logic [31:0] d);
    req_t r;
    r.op = op; r.addr = ad; r.data = d;
    req_q.push_back(r);
  endtask

  task automatic mon_ev(input int kind, input logic [31:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || (kind == EV_RD && e.data !== d)) begin
        failures++;
        $display("FAIL event got kind=%0d cyc=%0d data=%h expected kind=%0d cyc=%0d data=%h",
                 kind, cyc, d, e.kind, e.cyc, e.data);
      end
    end
  endtask

  // Monitor: every output pulse and every request cycle is matched against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (write_resp_valid) mon_ev(EV_WR, 32'h0);
      if (read_resp_valid)  mon_ev(EV_RD, data_in);
      if (rc_timeout)       mon_ev(EV_TMO, 32'h0);
      if (transfer_err)     mon_ev(EV_ERR, 32'h0);
      if (ifc.rc_req_valid) begin
        checks++;
        if (req_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_req addr=%h cyc=%0d", ifc.rc_req_address, cyc);
        end else if (ifc.rc_req_opcode !== req_q[0].op || ifc.rc_req_address !== req_q[0].addr ||
                     ifc.rc_req_data !== req_q[0].data) begin
          failures++;
          $display("FAIL req_fields got op=%b addr=%h data=%h expected op=%b addr=%h data=%h",
                   ifc.rc_req_opcode, ifc.rc_req_address, ifc.rc_req_data,
                   req_q[0].op, req_q[0].addr, req_q[0].data);
        end
        if (ifc.rc_req_ready && req_q.size() != 0) void'(req_q.pop_front());
      end
    end
  end

  task automatic rsp_cycle(input logic op, input logic [31:0] d);
    ifc.rc_rsp_valid = 1'b1; ifc.rc_rsp_opcode = op; ifc.rc_rsp_data = d;
    step();
    ifc.rc_rsp_valid = 1'b0; ifc.rc_rsp_opcode = 1'b0; ifc.rc_rsp_data = '0;
  endtask

  initial begin
    rst = 1'b1;
    write_transfer_valid = 1'b0; read_transfer_valid = 1'b0;
    address = '0; data_out = '0;
    ifc.rc_req_ready = 1'b0; ifc.rc_rsp_valid = 1'b0; ifc.rc_rsp_opcode = 1'b0; ifc.rc_rsp_data = '0;
    repeat (3) step();
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_req_valid", {31'h0, ifc.rc_req_valid}, 32'h0);
    check("rst_req_addr", ifc.rc_req_address, 32'h0);
    check("rst_data_in", data_in, 32'h0);
    rst = 1'b0;
    step();

    // Write, ready immediate, response one cycle after handshake
    ifc.rc_req_ready = 1'b1; address = 32'h0000_1000; data_out = 32'hDEAD_BEEF;
    write_transfer_valid = 1'b1;
    step(); a = cyc; write_transfer_valid = 1'b0;
    push_req(1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
    push_ev(EV_WR, 32'h0, a + 2);
    check("t1_busy", {31'h0, busy}, 32'h1);
    step();
    rsp_cycle(1'b1, 32'h0);
    step();
    check("t1_busy_after", {31'h0, busy}, 32'h0);

    // Read issued back-to-back, ready delayed 5 cycles
    ifc.rc_req_ready = 1'b0; address = 32'h0000_2004; data_out = 32'h1111_1111;
    read_transfer_valid = 1'b1;
    step(); a = cyc; read_transfer_valid = 1'b0;
    push_req(1'b0, 32'h0000_2004, 32'h0);
    push_ev(EV_RD, 32'h1234_5678, a + 7);
    repeat (5) step();
    ifc.rc_req_ready = 1'b1;
    step();
    ifc.rc_req_ready = 1'b0;
    rsp_cycle(1'b0, 32'h1234_5678);
    step();
    check("t2_data_in", data_in, 32'h1234_5678);

    // Silent RC: timeout 8 cycles after accept
    ifc.rc_req_ready = 1'b1; address = 32'h0000_3000;
    read_transfer_valid = 1'b1;
    step(); a = cyc; read_transfer_valid = 1'b0;
    push_req(1'b0, 32'h0000_3000, 32'h0);
    push_ev(EV_TMO, 32'h0, a + 8);
    repeat (9) step();
    check("t3_req_valid", {31'h0, ifc.rc_req_valid}, 32'h0);
    check("t3_busy", {31'h0, busy}, 32'h0);
    check("t3_data_in_kept", data_in, 32'h1234_5678);

    // Matching response in terminal-count cycle wins; mismatched opcode ignored
    address = 32'h0000_3004;
    read_transfer_valid = 1'b1;
    step(); a = cyc; read_transfer_valid = 1'b0;
    push_req(1'b0, 32'h0000_3004, 32'h0);
    push_ev(EV_RD, 32'hCAFE_F00D, a + 8);
    repeat (2) step();
    rsp_cycle(1'b1, 32'hFFFF_FFFF);
    repeat (4) step();
    rsp_cycle(1'b0, 32'hCAFE_F00D);
    step();
    check("t3b_data_in", data_in, 32'hCAFE_F00D);

    // Both pulses together, then a write pulse while busy
    address = 32'h0000_7000;
    write_transfer_valid = 1'b1; read_transfer_valid = 1'b1;
    step(); a = cyc; write_transfer_valid = 1'b0; read_transfer_valid = 1'b0;
    push_ev(EV_ERR, 32'h0, a);
    step();
    ifc.rc_req_ready = 1'b0; address = 32'h0000_4000; data_out = 32'h0000_0001;
    write_transfer_valid = 1'b1;
    step(); a = cyc;
    push_req(1'b1, 32'h0000_4000, 32'h0000_0001);
    address = 32'h0000_5000; data_out = 32'h0000_0002;
    step(); write_transfer_valid = 1'b0;
    push_ev(EV_ERR, 32'h0, a + 1);
    push_ev(EV_WR, 32'h0, a + 3);
    ifc.rc_req_ready = 1'b1;
    step();
    rsp_cycle(1'b1, 32'h0);
    step();
    check("t4_data_in_kept", data_in, 32'hCAFE_F00D);

    // Reset while waiting for the response
    address = 32'h0000_6000;
    read_transfer_valid = 1'b1;
    step(); read_transfer_valid = 1'b0;
    push_req(1'b0, 32'h0000_6000, 32'h0);
    step();
    rst = 1'b1;
    step();
    check("t5_busy", {31'h0, busy}, 32'h0);
    check("t5_req_valid", {31'h0, ifc.rc_req_valid}, 32'h0);
    check("t5_req_addr", ifc.rc_req_address, 32'h0);
    check("t5_data_in", data_in, 32'h0);
    check("t5_pulses", {28'h0, write_resp_valid, read_resp_valid, rc_timeout, transfer_err}, 32'h0);
    rst = 1'b0;
    rsp_cycle(1'b0, 32'h0000_0BAD);
    step();
    check("t5_data_in_idle_rsp", data_in, 32'h0);

    // Misaligned address: rejected only with the alignment check built in
    address = 32'h0000_1002; data_out = 32'h0000_0055;
    write_transfer_valid = 1'b1;
    step(); a = cyc; write_transfer_valid = 1'b0;
`ifdef RC_BRIDGE_ALIGN_CHECK_EN
    push_ev(EV_ERR, 32'h0, a);
    repeat (3) step();
`else
    push_req(1'b1, 32'h0000_1002, 32'h0000_0055);
    push_ev(EV_WR, 32'h0, a + 2);
    step();
    rsp_cycle(1'b1, 32'h0);
    step();
`endif
    check("t6_busy", {31'h0, busy}, 32'h0);

    repeat (3) step();
    check("exp_q_drained", exp_q.size(), 32'h0);
    check("req_q_drained", req_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
